// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for alu_seq.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_MUL = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Issue/writeback handshake bundle between the operand stage and alu_seq.
interface alu_seq_if #(parameter int unsigned WIDTH = 16);
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   op_t              op;
   logic [WIDTH-1:0] i0;
   logic [WIDTH-1:0] i1;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] o;
   logic [WIDTH-1:0] o_hi;
   logic             cout;
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, op, i0, i1, out_ready,
      input  in_ready, out_valid, o, o_hi, cout, zero, ovf
   );

   modport slave (
      input  in_valid, op, i0, i1, out_ready,
      output in_ready, out_valid, o, o_hi, cout, zero, ovf
   );

endinterface

// File: rtl/seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles total.
module seq_mul #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic [2*WIDTH-1:0] prod
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand;
   logic [CW-1:0]    cnt;

   // Add the multiplicand into the high half if the current low bit is set, then shift right.
   function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                               input logic [WIDTH-1:0]   m);
      logic [WIDTH:0] sum;
      sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : (WIDTH+1)'(0));
      return {sum, p[WIDTH-1:1]};
   endfunction

   // Bit 0 is folded into the start cycle so the last step lands on the cycle busy drops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy  <= 1'b0;
         prod  <= '0;
         mcand <= '0;
         cnt   <= '0;
      end else if (start) begin
         mcand <= a;
         prod  <= step({WIDTH'(0), b}, a);
         cnt   <= CW'(WIDTH - 2);
         busy  <= 1'b1;
      end else if (busy) begin
         prod <= step(prod, mcand);
         if (cnt == '0) busy <= 1'b0;
         else           cnt  <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic/shift, iterative multiply, registered results and flags.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic      clk,
   input  logic      reset,
   alu_seq_if.slave  bus
);

   localparam int unsigned CW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'(ST_IDLE);
   localparam logic [1:0] MUL  = 2'(ST_MUL);
   localparam logic [1:0] DONE = 2'(ST_DONE);

   logic [1:0]         state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   o_q, o_d, o_hi_q, o_hi_d;
   logic               cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
   logic               start_c;
   logic               busy;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH+1:0]   alu_res;

   // Single-cycle datapath; returns {cout, ovf, result}.
   function automatic logic [WIDTH+1:0] alu_f(input op_t op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      logic [WIDTH:0]     sum;
      logic [2*WIDTH-1:0] sh;
      logic [WIDTH-1:0]   r;
      logic [CW-1:0]      amt;
      logic               c, v;
      sum = '0;
      sh  = '0;
      r   = '0;
      c   = 1'b0;
      v   = 1'b0;
      amt = b[CW-1:0];
      case (op)
         OP_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            r   = sum[WIDTH-1:0];
            c   = sum[WIDTH];
            v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            r   = sum[WIDTH-1:0];
            c   = sum[WIDTH];
            v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         // Shifting through a double-width window leaves the last bit out right next to the result.
         OP_SHL: begin
            sh = {WIDTH'(0), a} << amt;
            r  = sh[WIDTH-1:0];
            c  = sh[WIDTH];
         end
         OP_SHR: begin
            sh = {a, WIDTH'(0)} >> amt;
            r  = sh[2*WIDTH-1:WIDTH];
            c  = sh[WIDTH-1];
         end
         default: r = '0;
      endcase
      return {c, v, r};
   endfunction

   always_comb alu_res = alu_f(bus.op, bus.i0, bus.i1);

   seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .reset (reset),
      .start (start_c),
      .a     (bus.i0),
      .b     (bus.i1),
      .busy  (busy),
      .prod  (prod)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         o_q         <= '0;
         o_hi_q      <= '0;
         cout_q      <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         o_q         <= o_d;
         o_hi_q      <= o_hi_d;
         cout_q      <= cout_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
      end
   end

   // Next state and next values of the registered outputs.
   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      o_d         = o_q;
      o_hi_d      = o_hi_q;
      cout_d      = cout_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      start_c     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               in_ready_d = 1'b0;
               if (bus.op == OP_MUL) begin
                  start_c = 1'b1;
                  state_d = MUL;
               end else begin
                  o_d         = alu_res[WIDTH-1:0];
                  o_hi_d      = '0;
                  cout_d      = alu_res[WIDTH+1];
                  ovf_d       = alu_res[WIDTH];
                  zero_d      = (alu_res[WIDTH-1:0] == '0);
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         MUL: begin
            if (!busy) begin
               o_d         = prod[WIDTH-1:0];
               o_hi_d      = prod[2*WIDTH-1:WIDTH];
               cout_d      = |prod[2*WIDTH-1:WIDTH];
               ovf_d       = 1'b0;
               zero_d      = (prod[WIDTH-1:0] == '0);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.o         = o_q;
   assign bus.o_hi      = o_hi_q;
   assign bus.cout      = cout_q;
   assign bus.zero      = zero_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=16 and WIDTH=32.
module tb_alu_seq;
   import alu_pkg::*;

   typedef struct packed {
      logic [31:0] o;
      logic [31:0] o_hi;
      logic        cout;
      logic        zero;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q16[$];
   exp_t q32[$];

   alu_seq_if #(.WIDTH(16)) b16 ();
   alu_seq_if #(.WIDTH(32)) b32 ();

   alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));
   alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input logic [31:0] o, input logic [31:0] hi,
                               input logic c, input logic z, input logic v);
      exp_t e;
      e.o = o; e.o_hi = hi; e.cout = c; e.zero = z; e.ovf = v;
      return e;
   endfunction

   // Reference behaviour for WIDTH=16 built from plain integer arithmetic.
   function automatic exp_t model16(input op_t op, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      int          sa, sb, s;
      int unsigned amt;
      logic [31:0] t;
      e = '0;
      sa = $signed(a);
      sb = $signed(b);
      amt = 32'(b[3:0]);
      case (op)
         OP_ADD: begin
            t = 32'(a) + 32'(b);
            e.o = 32'(t[15:0]);
            e.cout = (t > 32'h0000_ffff);
            s = sa + sb;
            e.ovf = (s > 32767) || (s < -32768);
         end
         OP_SUB: begin
            e.o = 32'(16'(a - b));
            e.cout = (a >= b);
            s = sa - sb;
            e.ovf = (s > 32767) || (s < -32768);
         end
         OP_AND: e.o = 32'(a & b);
         OP_OR:  e.o = 32'(a | b);
         OP_XOR: e.o = 32'(a ^ b);
         OP_SHL: begin
            t = 32'(a) << amt;
            e.o = 32'(t[15:0]);
            e.cout = (amt == 0) ? 1'b0 : a[16 - amt];
         end
         OP_SHR: begin
            e.o = 32'(a >> amt);
            e.cout = (amt == 0) ? 1'b0 : a[amt - 1];
         end
         default: begin
            t = 32'(a) * 32'(b);
            e.o = 32'(t[15:0]);
            e.o_hi = 32'(t[31:16]);
            e.cout = (t[31:16] != 16'h0);
         end
      endcase
      e.zero = (e.o == 32'h0);
      return e;
   endfunction

   // Scoreboard: each result hand-off pops the oldest expectation.
   always @(negedge clk) begin
      if (reset && b16.out_valid && b16.out_ready) begin
         exp_t e;
         checks++;
         if (q16.size() == 0) begin
            errors++;
            $display("FAIL sb16_unexpected got o=%h with no expected entry", b16.o);
         end else begin
            e = q16.pop_front();
            if (32'(b16.o) !== e.o || 32'(b16.o_hi) !== e.o_hi || b16.cout !== e.cout ||
                b16.zero !== e.zero || b16.ovf !== e.ovf) begin
               errors++;
               $display("FAIL sb16 got o=%h hi=%h c=%b z=%b v=%b required o=%h hi=%h c=%b z=%b v=%b",
                        b16.o, b16.o_hi, b16.cout, b16.zero, b16.ovf,
                        e.o[15:0], e.o_hi[15:0], e.cout, e.zero, e.ovf);
            end
         end
      end
      if (reset && b32.out_valid && b32.out_ready) begin
         exp_t e;
         checks++;
         if (q32.size() == 0) begin
            errors++;
            $display("FAIL sb32_unexpected got o=%h with no expected entry", b32.o);
         end else begin
            e = q32.pop_front();
            if (b32.o !== e.o || b32.o_hi !== e.o_hi || b32.cout !== e.cout ||
                b32.zero !== e.zero || b32.ovf !== e.ovf) begin
               errors++;
               $display("FAIL sb32 got o=%h hi=%h c=%b z=%b v=%b required o=%h hi=%h c=%b z=%b v=%b",
                        b32.o, b32.o_hi, b32.cout, b32.zero, b32.ovf,
                        e.o, e.o_hi, e.cout, e.zero, e.ovf);
            end
         end
      end
   end

   task automatic issue16(input op_t op, input logic [15:0] a, input logic [15:0] b,
                          input bit push, input exp_t e, output int acc_cyc);
      bit ok = 1'b0;
      b16.op = op; b16.i0 = a; b16.i1 = b; b16.in_valid = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = b16.in_ready;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL issue16_accept in_ready=%b required 1", b16.in_ready);
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      b16.in_valid = 1'b0;
      if (push) q16.push_back(e);
   endtask

   task automatic issue32(input op_t op, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, output int acc_cyc);
      bit ok = 1'b0;
      b32.op = op; b32.i0 = a; b32.i1 = b; b32.in_valid = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = b32.in_ready;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL issue32_accept in_ready=%b required 1", b32.in_ready);
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      b32.in_valid = 1'b0;
      q32.push_back(e);
   endtask

   // Counts clock edges from the acceptance edge until out_valid is seen; -1 on timeout.
   task automatic wait16(output int lat);
      bit seen = 1'b0;
      lat = 0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         lat++;
         seen = b16.out_valid;
      end
      if (!seen) lat = -1;
   endtask

   task automatic wait32(output int lat);
      bit seen = 1'b0;
      lat = 0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         lat++;
         seen = b32.out_valid;
      end
      if (!seen) lat = -1;
   endtask

   task automatic run16(input op_t op, input logic [15:0] a, input logic [15:0] b,
                        input exp_t e, input int exp_lat);
      int acc, lat;
      issue16(op, a, b, 1'b1, e, acc);
      wait16(lat);
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("FAIL lat16 op=%s got %0d required %0d", op.name(), lat, exp_lat);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run32(input op_t op, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input int exp_lat);
      int acc, lat;
      issue32(op, a, b, e, acc);
      wait32(lat);
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("FAIL lat32 op=%s got %0d required %0d", op.name(), lat, exp_lat);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({b16.out_valid, b16.o, b16.o_hi, b16.cout, b16.zero, b16.ovf} !== '0 || b16.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset16 got v=%b rdy=%b o=%h hi=%h flags=%b%b%b required all 0, rdy=1",
                  b16.out_valid, b16.in_ready, b16.o, b16.o_hi, b16.cout, b16.zero, b16.ovf);
      end
      checks++;
      if ({b32.out_valid, b32.o, b32.o_hi, b32.cout, b32.zero, b32.ovf} !== '0 || b32.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset32 got v=%b rdy=%b o=%h required all 0, rdy=1",
                  b32.out_valid, b32.in_ready, b32.o);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset16_release got rdy=%b v=%b required rdy=1 v=0", b16.in_ready, b16.out_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_arith16();
      run16(OP_ADD, 16'hffff, 16'h0001, mk(32'h0000, 0, 1, 1, 0), 1);
      run16(OP_ADD, 16'h0001, 16'h7fff, mk(32'h8000, 0, 0, 0, 1), 1);
      run16(OP_SUB, 16'haa55, 16'h55aa, mk(32'h54ab, 0, 1, 0, 1), 1);
      run16(OP_SUB, 16'h0000, 16'h0001, mk(32'hffff, 0, 0, 0, 0), 1);
      run16(OP_AND, 16'hf0f0, 16'hff00, mk(32'hf000, 0, 0, 0, 0), 1);
      run16(OP_OR,  16'hf0f0, 16'h0f00, mk(32'hfff0, 0, 0, 0, 0), 1);
      run16(OP_XOR, 16'h1234, 16'h1234, mk(32'h0000, 0, 0, 1, 0), 1);
      run16(OP_SHL, 16'h8001, 16'h0001, mk(32'h0002, 0, 1, 0, 0), 1);
      run16(OP_SHL, 16'h8001, 16'h0000, mk(32'h8001, 0, 0, 0, 0), 1);
      run16(OP_SHR, 16'h0003, 16'h0011, mk(32'h0001, 0, 1, 0, 0), 1);
      run16(OP_SHR, 16'h8000, 16'h000f, mk(32'h0001, 0, 0, 0, 0), 1);
   endtask

   task automatic test_mul16();
      run16(OP_MUL, 16'hffff, 16'hffff, mk(32'h0001, 32'hfffe, 1, 0, 0), 17);
      run16(OP_MUL, 16'hffff, 16'h0001, mk(32'hffff, 32'h0000, 0, 0, 0), 17);
      run16(OP_MUL, 16'h0100, 16'h0100, mk(32'h0000, 32'h0001, 1, 1, 0), 17);
   endtask

   task automatic test_random16();
      for (int i = 0; i < 24; i++) begin
         op_t         op;
         logic [15:0] a, b;
         op = op_t'(3'($urandom_range(0, 7)));
         a = 16'($urandom);
         b = 16'($urandom);
         run16(op, a, b, model16(op, a, b), (op == OP_MUL) ? 17 : 1);
      end
   endtask

   task automatic test_back_to_back();
      op_t ops[6] = '{OP_ADD, OP_XOR, OP_SUB, OP_MUL, OP_SHR, OP_OR};
      int  prev, acc;
      logic [15:0] a, b;
      prev = 0;
      for (int i = 0; i < 6; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         issue16(ops[i], a, b, 1'b1, model16(ops[i], a, b), acc);
         if (i > 0) begin
            checks++;
            if (acc - prev != ((ops[i-1] == OP_MUL) ? 18 : 2)) begin
               errors++;
               $display("FAIL b2b_spacing after %s got %0d required %0d", ops[i-1].name(),
                        acc - prev, (ops[i-1] == OP_MUL) ? 18 : 2);
            end
         end
         prev = acc;
      end
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      int acc, lat;
      b16.out_ready = 1'b0;
      issue16(OP_ADD, 16'h1234, 16'h1111, 1'b1, mk(32'h2345, 0, 0, 0, 0), acc);
      wait16(lat);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL bp_lat got %0d required 1", lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         b16.in_valid = 1'b1; b16.op = OP_XOR; b16.i0 = 16'h00ff; b16.i1 = 16'hff00;
         @(negedge clk);
         checks++;
         if (b16.out_valid !== 1'b1 || b16.in_ready !== 1'b0 || b16.o !== 16'h2345 ||
             b16.o_hi !== 16'h0 || b16.cout !== 1'b0 || b16.zero !== 1'b0 || b16.ovf !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got v=%b rdy=%b o=%h required v=1 rdy=0 o=2345",
                     i, b16.out_valid, b16.in_ready, b16.o);
         end
      end
      @(posedge clk);
      #1;
      b16.in_valid = 1'b0;
      b16.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release got rdy=%b v=%b required rdy=1 v=0", b16.in_ready, b16.out_valid);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (b16.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_ignored got v=%b required 0", b16.out_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_mul();
      int acc;
      run16(OP_ADD, 16'h1000, 16'h0234, mk(32'h1234, 0, 0, 0, 0), 1);
      issue16(OP_MUL, 16'hffff, 16'hffff, 1'b0, '0, acc);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({b16.out_valid, b16.o, b16.o_hi, b16.cout, b16.zero, b16.ovf} !== '0) begin
         errors++;
         $display("FAIL rst_mid_mul got v=%b o=%h hi=%h flags=%b%b%b required all 0",
                  b16.out_valid, b16.o, b16.o_hi, b16.cout, b16.zero, b16.ovf);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_mul_release got rdy=%b v=%b required rdy=1 v=0", b16.in_ready, b16.out_valid);
      end
      @(posedge clk);
      #1;
      run16(OP_ADD, 16'h0002, 16'h0003, mk(32'h0005, 0, 0, 0, 0), 1);
      run16(OP_MUL, 16'h0003, 16'h0007, mk(32'h0015, 0, 0, 0, 0), 17);
   endtask

   task automatic test_width32();
      run32(OP_ADD, 32'hffff_ffff, 32'h0000_0001, mk(32'h0, 32'h0, 1, 1, 0), 1);
      run32(OP_SUB, 32'h0000_0000, 32'h0000_0001, mk(32'hffff_ffff, 32'h0, 0, 0, 0), 1);
      run32(OP_SHL, 32'h8000_0001, 32'h0000_0021, mk(32'h0000_0002, 32'h0, 1, 0, 0), 1);
      run32(OP_MUL, 32'hffff_ffff, 32'hffff_ffff, mk(32'h0000_0001, 32'hffff_fffe, 1, 0, 0), 33);
      run32(OP_MUL, 32'hffff_ffff, 32'h0000_0001, mk(32'hffff_ffff, 32'h0, 0, 0, 0), 33);
   endtask

   initial begin
      b16.in_valid = 1'b0; b16.op = OP_ADD; b16.i0 = '0; b16.i1 = '0; b16.out_ready = 1'b1;
      b32.in_valid = 1'b0; b32.op = OP_ADD; b32.i0 = '0; b32.i1 = '0; b32.out_ready = 1'b1;
      test_reset();
      test_arith16();
      test_mul16();
      test_random16();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_mul();
      test_width32();
      repeat (3) @(posedge clk);
      checks++;
      if (q16.size() != 0 || q32.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got pending16=%0d pending32=%0d required 0 and 0", q16.size(), q32.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
